// File: rtl/celda_inicial_pkg.sv
// Shared definitions for the MSB-first iterative magnitude comparator chain.
// Cascade flag encoding (f,g): 00 equal so far, 10 A greater, 01 B greater.
// Encoding 11 never occurs.
package celda_inicial_pkg;

    localparam int CMP_WIDTH = 3;

    typedef struct packed {
        logic f;  // A already greater
        logic g;  // B already greater
    } cmp_flags_t;

    localparam cmp_flags_t FLAGS_EQUAL   = 2'b00;
    localparam cmp_flags_t FLAGS_A_GREATER = 2'b10;
    localparam cmp_flags_t FLAGS_B_GREATER = 2'b01;

    // Decide a single bit position: a differing bit settles the comparison.
    function automatic cmp_flags_t compare_bit(input logic a_bit, input logic b_bit);
        cmp_flags_t r;
        r.f = a_bit & ~b_bit;
        r.g = ~a_bit & b_bit;
        return r;
    endfunction

endpackage

// File: rtl/celda_inicial.sv
// First cell of the MSB-first comparator chain. Looks only at the top bit of
// A and B and registers the cascade flags for the next cell. There is no
// enable or handshake: the flags reload on every rising clock edge.
module celda_inicial
    import celda_inicial_pkg::*;
#(
    parameter int WIDTH = CMP_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             f_in,
    output logic             g_in
);

    cmp_flags_t flags_next;
    cmp_flags_t flags_q;

    // Compare the most significant bits; lower bits belong to later cells.
    always_comb begin
        flags_next = compare_bit(A[WIDTH-1], B[WIDTH-1]);
    end

    // Flag register, cleared asynchronously so reset discards in-flight values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= FLAGS_EQUAL;
        end else begin
            flags_q <= flags_next;
        end
    end

    assign f_in = flags_q.f;
    assign g_in = flags_q.g;

endmodule

// File: tb/tb_celda_inicial.sv
// Bench for celda_inicial: table of directed vectors plus hand-written
// sequences for asynchronous reset and mid-cycle operand changes.
module tb_celda_inicial;

    logic       clk;
    logic       rst_n;
    logic [2:0] A;
    logic [2:0] B;
    logic       f_in;
    logic       g_in;

    int n_vectors;
    int n_miscompares;

    typedef struct {
        logic [2:0] a;
        logic [2:0] b;
        logic [1:0] exp_fg;
    } vec_t;

    vec_t vecs[$];

    celda_inicial #(.WIDTH(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .B     (B),
        .f_in  (f_in),
        .g_in  (g_in)
    );

    // Clock generation
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [1:0] expected);
        n_vectors++;
        if ({f_in, g_in} !== expected) begin
            n_miscompares++;
            $display("FAIL %s: got f_in,g_in=%b%b, required %b", name, f_in, g_in, expected);
        end
    endtask

    task automatic apply(input logic [2:0] a, input logic [2:0] b);
        @(negedge clk);
        A = a;
        B = b;
    endtask

    initial begin
        n_vectors     = 0;
        n_miscompares = 0;

        // Table: {A, B, expected {f_in,g_in}} after one clock
        vecs.push_back('{3'b000, 3'b000, 2'b00});
        vecs.push_back('{3'b001, 3'b010, 2'b00});
        vecs.push_back('{3'b110, 3'b011, 2'b10});
        vecs.push_back('{3'b111, 3'b101, 2'b00});
        vecs.push_back('{3'b011, 3'b100, 2'b01});
        vecs.push_back('{3'b100, 3'b000, 2'b10});
        vecs.push_back('{3'b000, 3'b111, 2'b01});
        vecs.push_back('{3'b111, 3'b111, 2'b00});
        vecs.push_back('{3'b101, 3'b010, 2'b10});
        vecs.push_back('{3'b010, 3'b110, 2'b01});

        // Asynchronous reset with operands that would set f_in
        rst_n = 1'b1;
        A     = 3'b111;
        B     = 3'b000;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_immediate", 2'b00);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("reset_held", 2'b00);
        end

        // First edge after release loads from current operands
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_release_load", 2'b10);

        // Table-driven vectors
        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].a, vecs[i].b);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_%b_%b", i, vecs[i].a, vecs[i].b), vecs[i].exp_fg);
        end

        // Mid-cycle operand change has no effect until the next edge
        apply(3'b000, 3'b000);
        @(posedge clk);
        #1;
        check("midcycle_base", 2'b00);
        #2;
        A = 3'b110;
        B = 3'b011;
        #1;
        check("midcycle_no_effect", 2'b00);
        @(posedge clk);
        #1;
        check("midcycle_next_edge", 2'b10);

        // Reset asserted between edges clears the flags at once
        #2;
        rst_n = 1'b0;
        #1;
        check("midop_reset_clear", 2'b00);
        @(posedge clk);
        #1;
        check("midop_reset_held", 2'b00);

        // Recovery loads B-greater directly
        @(negedge clk);
        A     = 3'b011;
        B     = 3'b100;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("recover_load", 2'b01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "timeout");
    end

endmodule
